// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised data memory: the controller
// state encoding and the default geometry.
package mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;

    // CLEAR zeroes every word after reset. READY serves read/write requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage : mem_pkg

// File: rtl/mem_array_sp.sv
// Single-port storage array: synchronous write, asynchronous (combinational)
// read. The same address serves both, so the controller decides which
// address is presented each cycle.
module mem_array_sp #(
    parameter int DATA_W = mem_pkg::DATA_W_DEF,
    parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
    parameter int DEPTH  = mem_pkg::DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Word write on the rising edge when enabled.
    // NOTE: the array has no reset branch; a reset term would turn it into
    // thousands of flops. The controller zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Combinational read of the addressed word; out-of-range values are
    // masked by the controller and never reach the output register.
    assign rdata = mem_q[addr];

endmodule : mem_array_sp

// File: rtl/data_mem_param.sv
// Parameterised data memory with a post-reset clear sequence, one-cycle
// registered reads, write-first bypass and out-of-range detection.
module data_mem_param
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] aluout_in,
    output logic [DATA_W-1:0] memtoreg_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              addr_err
);

    // One extra counter bit so DEPTH = 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   memtoreg_q, memtoreg_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;

    logic                in_range;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    assign in_range = ({1'b0, address_in} < DEPTH_EXT);

    mem_array_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk    (clk),
        .we     (mem_we),
        .addr   (mem_addr),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata)
    );

    // Next-state, clear sequencing, storage port steering and read result.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memtoreg_d = memtoreg_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = address_in;
        mem_wdata  = aluout_in;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q[ADDR_W-1:0];
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we     = mem_write && in_range;
                addr_err_d = (mem_read || mem_write) && !in_range;
                if (mem_read) begin
                    rd_valid_d = 1'b1;
                    if (!in_range) begin
                        memtoreg_d = '0;
                    end else if (mem_write) begin
                        // Write-first: the word being written is returned.
                        memtoreg_d = aluout_in;
                    end else begin
                        memtoreg_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // Storage is untouched while reset is held.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // State and output registers with synchronous reset restarting the clear.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            memtoreg_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memtoreg_q <= memtoreg_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign memtoreg_out = memtoreg_q;
    assign rd_valid     = rd_valid_q;
    assign addr_err     = addr_err_q;
    assign ready        = (state_q == READY);

endmodule : data_mem_param

// File: tb/tb_data_mem_param.sv
// Self-checking bench for data_mem_param (DATA_W=8, ADDR_W=8, DEPTH=200).
// Read expectations come from a reference word array and are queued when a
// read is issued, then compared when rd_valid is observed.
module tb_data_mem_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address_in;
    logic [DATA_W-1:0] aluout_in;
    logic [DATA_W-1:0] memtoreg_out;
    logic              rd_valid;
    logic              ready;
    logic              addr_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mdl [256];

    data_mem_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address_in   (address_in),
        .aluout_in    (aluout_in),
        .memtoreg_out (memtoreg_out),
        .rd_valid     (rd_valid),
        .ready        (ready),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed read result is matched against the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(memtoreg_out), 32'(e));
            end
        end
    end

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address_in = '0;
        aluout_in  = '0;
    endtask

    // Hold reset for n edges, check reset outputs, then release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1;
        check("rst_memtoreg", 32'(memtoreg_out), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ready",    32'(ready),    32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        for (int i = 0; i < 256; i++) mdl[i] = '0;
        rst = 1'b0;
    endtask

    // Count edges until ready; optionally hammer requests during the clear.
    task automatic wait_ready(input bit drive_req);
        int cycles = 0;
        int bad    = 0;
        if (drive_req) begin
            mem_read   = 1'b1;
            mem_write  = 1'b1;
            address_in = 8'd3;
            aluout_in  = 8'h77;
        end
        while (ready !== 1'b1 && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rd_valid !== 1'b0 || addr_err !== 1'b0) bad++;
        end
        idle_inputs();
        check("ready_latency", 32'(cycles), 32'(DEPTH));
        check("clear_quiet", 32'(bad), 32'd0);
    endtask

    // One request cycle against the reference array.
    task automatic do_op(input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        logic in_rng;
        in_rng     = (int'(addr) < DEPTH);
        mem_read   = rd;
        mem_write  = wr;
        address_in = addr;
        aluout_in  = data;
        if (rd) exp_q.push_back(!in_rng ? 8'h00 : (wr ? data : mdl[addr]));
        if (wr && in_rng) mdl[addr] = data;
        @(posedge clk);
        #1;
        check("addr_err", 32'(addr_err), 32'((rd || wr) && !in_rng));
        check("rd_valid", 32'(rd_valid), 32'(rd));
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset release, clear duration, cleared words read back-to-back.
        do_reset(3);
        wait_ready(1'b0);
        do_op(1'b1, 1'b0, 8'd0,   8'h00);
        do_op(1'b1, 1'b0, 8'd99,  8'h00);
        do_op(1'b1, 1'b0, 8'd199, 8'h00);
        check("r199_zero", 32'(memtoreg_out), 32'h00);

        // Write then read.
        do_op(1'b0, 1'b1, 8'd7, 8'hA5);
        do_op(1'b1, 1'b0, 8'd7, 8'h00);
        check("r7_data", 32'(memtoreg_out), 32'hA5);

        // No read: rd_valid low, data held.
        @(posedge clk);
        #1;
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_data",  32'(memtoreg_out), 32'hA5);

        // Same-cycle write and read is write-first.
        do_op(1'b1, 1'b1, 8'd12, 8'h3C);
        check("wf_data", 32'(memtoreg_out), 32'h3C);

        // Out-of-range write dropped, read returns zero, error pulses.
        do_op(1'b0, 1'b1, 8'd250, 8'hFF);
        do_op(1'b1, 1'b0, 8'd250, 8'h00);
        check("oor_data", 32'(memtoreg_out), 32'h00);
        @(posedge clk);
        #1;
        check("oor_err_clear", 32'(addr_err), 32'd0);
        do_op(1'b1, 1'b0, 8'd7,   8'h00);
        do_op(1'b1, 1'b0, 8'd50,  8'h00);
        do_op(1'b1, 1'b0, 8'd199, 8'h00);
        do_op(1'b1, 1'b0, 8'd0,   8'h00);
        do_op(1'b1, 1'b0, 8'd12,  8'h00);

        // Random mixed traffic, including out-of-range addresses.
        for (int i = 0; i < 80; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom));
        end

        // Reset from READY, then again mid-clear at count 50.
        do_op(1'b0, 1'b1, 8'd5, 8'h11);
        do_op(1'b1, 1'b0, 8'd5, 8'h00);
        check("r5_written", 32'(memtoreg_out), 32'h11);
        do_reset(1);
        repeat (50) @(posedge clk);
        #1;
        check("mid_clear_ready", 32'(ready), 32'd0);
        do_reset(1);
        wait_ready(1'b0);
        do_op(1'b1, 1'b0, 8'd5, 8'h00);
        check("r5_cleared", 32'(memtoreg_out), 32'h00);

        // Requests during clear are ignored.
        do_reset(2);
        wait_ready(1'b1);
        do_op(1'b1, 1'b0, 8'd3, 8'h00);
        check("r3_ignored", 32'(memtoreg_out), 32'h00);

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_param
